// File: rtl/fifo_queue_pkg.sv
// Shared definitions for the fifo_queue block: default geometry, threshold
// levels and the {wr, rd} operation encoding used by the controller.
package fifo_queue_pkg;

  localparam int DEF_B      = 4;
  localparam int DEF_W      = 3;
  localparam int DEF_AF_LVL = 6;
  localparam int DEF_AE_LVL = 2;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_WRRD = 2'b11
  } op_e;

  function automatic op_e encode_op(input logic wr, input logic rd);
    return op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/fifo_queue_ctrl.sv
// Pointer, occupancy and flag controller for the circular FIFO.
// All status flags are registered from the next-state occupancy.
module fifo_ctrl
  import fifo_queue_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_i,
  input  logic         rd_i,
  output logic [W-1:0] w_addr_o,
  output logic [W-1:0] r_addr_o,
  output logic         we_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         almost_empty_o,
  output logic         almost_full_o,
  output logic [W:0]   count_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  localparam logic [W:0] FULL_CNT = (W+1)'(1 << W);
  localparam logic [W:0] AF_CNT   = (W+1)'(AF_LVL);
  localparam logic [W:0] AE_CNT   = (W+1)'(AE_LVL);

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, full_q, almost_empty_q, almost_full_q;
  logic         overflow_q, underflow_q;
  logic         do_wr, do_rd, ovf_set, unf_set;
  op_e          op;

  // A simultaneous read on a full queue frees the slot the write lands in,
  // so only a lone write can overflow and only a lone read can underflow.
  always_comb begin
    op      = encode_op(wr_i, rd_i);
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OP_WR: begin
        if (full_q) ovf_set = 1'b1;
        else        do_wr   = 1'b1;
      end
      OP_RD: begin
        if (empty_q) unf_set = 1'b1;
        else         do_rd   = 1'b1;
      end
      OP_WRRD: begin
        do_wr = 1'b1;
        do_rd = !empty_q;
      end
      default: ;
    endcase

    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;

    w_ptr_d = do_wr ? w_ptr_q + 1'b1 : w_ptr_q;
    r_ptr_d = do_rd ? r_ptr_q + 1'b1 : r_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_ptr_q        <= '0;
      r_ptr_q        <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      w_ptr_q        <= w_ptr_d;
      r_ptr_q        <= r_ptr_d;
      count_q        <= count_d;
      empty_q        <= (count_d == '0);
      full_q         <= (count_d == FULL_CNT);
      almost_empty_q <= (count_d <= AE_CNT);
      almost_full_q  <= (count_d >= AF_CNT);
      overflow_q     <= overflow_q | ovf_set;
      underflow_q    <= underflow_q | unf_set;
    end
  end

  assign w_addr_o       = w_ptr_q;
  assign r_addr_o       = r_ptr_q;
  assign we_o           = do_wr;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = almost_empty_q;
  assign almost_full_o  = almost_full_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/fifo_queue.sv
// First-word fall-through circular FIFO: register-file storage plus the
// fifo_ctrl pointer/flag logic; the head word is forced to zero while empty.
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int B      = DEF_B,
  parameter int W      = DEF_W,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int DEPTH = 1 << W;

  logic [W-1:0] w_addr;
  logic [W-1:0] r_addr;
  logic         we;
  logic [B-1:0] mem_q [DEPTH];

  fifo_ctrl #(
    .W      (W),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) u_ctrl (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_i           (wr),
    .rd_i           (rd),
    .w_addr_o       (w_addr),
    .r_addr_o       (r_addr),
    .we_o           (we),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (almost_empty),
    .almost_full_o  (almost_full),
    .count_o        (count),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  // Storage is deliberately left out of reset; the empty flag masks stale words.
  always_ff @(posedge clk) begin
    if (we) mem_q[w_addr] <= w_data;
  end

  assign r_data = empty ? '0 : mem_q[r_addr];

endmodule
